csr_unit: RTL and testbench
===========================

Name: csr_unit

Overview:
- Next-generation machine-mode CSR file for the RV32 core, sitting beside the decoder and the trap/PC logic.
- Adds the following to the basic CSR register set:
  - mstatus MIE/MPIE stacking on trap entry and mret.
  - Parametrised local interrupt lines with mip/mie masking, priority select and interrupt request generation.
  - Direct and vectored mtvec modes.
  - 64-bit mcycle/minstret counters.
  - Illegal-access flagging.

Parameters:
- IRQ_NUM, 16: number of local interrupt lines, legal range 1..16. They map to mip/mie bits [16+IRQ_NUM-1:16].
- MTVEC_RESET, 32'h0000_0000: reset value of mtvec.
- COUNTERS_EN, 1: when 1, instantiate mcycle/minstret. When 0, the counter CSRs read 0 and are treated as unmapped.

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: reset, asynchronous, active-high.
- trap_i, in, 1: take trap this cycle.
- mret_i, in, 1: mret retiring this cycle.
- opcode_i, in, 3: CSR operation (RW/RS/RC/RWI/RSI/RCI).
- addr_i, in, 12: CSR address.
- write_enable_i, in, 1: CSR instruction writes this cycle.
- pc_i, in, 32: PC of the trapping instruction.
- mcause_i, in, 32: cause for trap_i.
- rs1_data_i, in, 32: register source operand.
- imm_data_i, in, 32: zero-extended uimm.
- irq_i, in, IRQ_NUM: level interrupt lines.
- instret_i, in, 1: an instruction retired this cycle.
- read_data_o, out, 32: CSR read data, combinational.
- illegal_o, out, 1: illegal CSR access, combinational.
- mie_o, out, 32: mie register.
- mepc_o, out, 32: mepc register.
- trap_pc_o, out, 32: trap target PC.
- irq_req_o, out, 1: interrupt request to the core.
- irq_cause_o, out, 32: mcause value for the pending interrupt.

Behaviour:
- **Reset values:**
  - mstatus = 0x0000_1800 (MPP hardwired 2'b11, MIE=0, MPIE=0).
  - mie, mscratch, mepc, mcause, mip, mcycle, minstret = 0.
  - mtvec = MTVEC_RESET.
  - All outputs derive from these values.
  - Reset mid-operation aborts any pending update; nothing is retained.
- **Write value:**
  - RW: src. RS: old | src. RC: old & ~src.
  - src = rs1_data_i for RW/RS/RC, imm_data_i for the I-forms.
  - Opcodes outside these six: no write, and illegal_o=1 if write_enable_i.
- **CSR writes:** a write commits on the clk_i edge when write_enable_i=1 and addr_i is a writable mapped CSR. Read data is combinational; the old value is visible in the same cycle.
- **Register map:** mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344 (read-only), mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82.
- **Unmapped addresses:** read_data_o=0 and illegal_o=write_enable_i. A write to mip also sets illegal_o=1; no register changes.
- **WARL fields:**
  - mstatus: only bits 3 and 7 are writable.
  - mepc: bits[1:0] forced 0.
  - mie: only bits [16+IRQ_NUM-1:16] are writable.
  - mtvec: mode field bits[1:0] written 2 or 3 stores 0.
- **Event priority per cycle:** trap_i > mret_i > CSR write.
  - trap_i: mepc <= {pc_i[31:2],2'b00}; mcause <= mcause_i; MPIE <= MIE; MIE <= 0. Any coincident CSR write to mstatus/mepc/mcause is dropped; writes to other CSRs still commit.
  - mret_i: MIE <= MPIE; MPIE <= 1. A coincident CSR write to mstatus is dropped.
- **trap_pc_o (combinational):**
  - Direct mode, or mcause_i[31]=0: trap_pc_o = {mtvec[31:2],2'b00}.
  - Vectored mode (mtvec[1:0]=1) with mcause_i[31]=1: trap_pc_o = base + 4*mcause_i[30:0], modulo 2^32.
- **Interrupts:**
  - mip[16+k] <= irq_i[k] every cycle; this is the one-cycle synchroniser stage.
  - irq_req_o = MIE & |(mip & mie).
  - irq_cause_o = {1'b1, 31'(16+k)}, where k is the lowest-index pending-and-enabled line. It is 0 when none is pending.
- **Counters (COUNTERS_EN=1):**
  - mcycle increments every cycle; minstret increments when instret_i=1.
  - Both are 64-bit and wrap from 2^64-1 to 0.
  - A CSR write to either half replaces that half, and the increment is suppressed for that counter in that cycle. The other half keeps its value, with no carry.

Decomposition:
- **csr_pkg:**
  - Opcode enum (CSR_RW..CSR_RCI).
  - All CSR address localparams, including the new MSTATUS/MIP/MCYCLE(H)/MINSTRET(H) addresses.
  - mstatus bit indices (MIE=3, MPIE=7) and the IRQ base index 16.
- **Sub-module csr_counter64:** a 64-bit counter with an increment enable, lo/hi write enables and write data. It is instantiated twice.

Test Plan:
- **Reset defaults:** assert rst_i mid-stream with mie=0xFFFF0000 → mie_o=0, read mstatus=0x1800, read mtvec=MTVEC_RESET, irq_req_o=0.
- **RS/RC semantics and WARL masks:**
  - CSRRS mie with rs1=0x0001_0001, then CSRRC with 0x0001_0000 → mie reads 0x0001_0000, then 0.
  - Write mtvec=0x0000_1003 → reads 0x0000_1000.
- **Trap entry, mret and vectored target:**
  - Set MIE=1, mtvec=0x100|1.
  - trap_i with pc_i=0x2002, mcause_i=0x8000_0013 → trap_pc_o=0x14C; next cycle mepc=0x2000, mcause=0x8000_0013, mstatus=0x1880.
  - mret_i → mstatus=0x1888.
- **Interrupt priority:**
  - mie=0x0005_0000, MIE=1, irq_i[2] and irq_i[0] both asserted → irq_req_o rises one cycle later, irq_cause_o=0x8000_0010.
  - Clear MIE → irq_req_o=0.
- **Counter wrap and write precedence:**
  - Write mcycle=0xFFFF_FFFF, mcycleh=0xFFFF_FFFF → two cycles later both halves read 0.
  - Write minstret while instret_i=1 → the written value holds, not +1.
- **Simultaneous events and illegal access:**
  - trap_i with a coincident CSRRW mepc=0x40 → mepc holds the trap PC.
  - CSRRW to 0x7C0 or to mip → illegal_o=1 and no state change.

Source files
------------

// File: rtl/csr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : csr_pkg
// Brief    : Shared opcodes, CSR addresses and field indices for the M-mode CSR file.
// Revision : 1.0
// ============================================================================
package csr_pkg;

    // Encodings follow the funct3 field of the SYSTEM opcode; 0 and 4 are illegal.
    typedef enum logic [2:0] {
        CSR_RW  = 3'd1,
        CSR_RS  = 3'd2,
        CSR_RC  = 3'd3,
        CSR_RWI = 3'd5,
        CSR_RSI = 3'd6,
        CSR_RCI = 3'd7
    } csr_op_e;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int IRQ_BASE     = 16;

    // MPP is hardwired to machine mode.
    localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;

endpackage
`default_nettype wire

// File: rtl/csr_counter64.sv
`default_nettype none
// ============================================================================
// Module   : csr_counter64
// Brief    : 64-bit wrapping counter with independently writable 32-bit halves.
// Revision : 1.0
// ============================================================================
module csr_counter64 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] count_o
);

    logic [63:0] r_count;

    // A write to either half takes precedence over the increment for the whole counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) r_count[31:0]  <= wdata_i;
            if (wr_hi_i) r_count[63:32] <= wdata_i;
        end else if (inc_i) begin
            r_count <= r_count + 64'd1;
        end
    end

    assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/csr_unit.sv
`default_nettype none
// ============================================================================
// Module   : csr_unit
// Brief    : RV32 machine-mode CSR file with trap/mret stacking, local IRQs and counters.
// Revision : 1.0
// ============================================================================
module csr_unit
    import csr_pkg::*;
#(
    parameter int          IRQ_NUM     = 16,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter bit          COUNTERS_EN = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               trap_i,
    input  logic               mret_i,
    input  logic [2:0]         opcode_i,
    input  logic [11:0]        addr_i,
    input  logic               write_enable_i,
    input  logic [31:0]        pc_i,
    input  logic [31:0]        mcause_i,
    input  logic [31:0]        rs1_data_i,
    input  logic [31:0]        imm_data_i,
    input  logic [IRQ_NUM-1:0] irq_i,
    input  logic               instret_i,
    output logic [31:0]        read_data_o,
    output logic               illegal_o,
    output logic [31:0]        mie_o,
    output logic [31:0]        mepc_o,
    output logic [31:0]        trap_pc_o,
    output logic               irq_req_o,
    output logic [31:0]        irq_cause_o
);

    localparam logic [31:0] C_MIE_MASK = 32'(((64'd1 << IRQ_NUM) - 64'd1) << IRQ_BASE);

    logic               r_mstatus_mie;
    logic               r_mstatus_mpie;
    logic [31:0]        r_mie;
    logic [31:0]        r_mtvec;
    logic [31:0]        r_mscratch;
    logic [31:0]        r_mepc;
    logic [31:0]        r_mcause;
    logic [IRQ_NUM-1:0] r_mip;

    logic [31:0] w_mstatus;
    logic [31:0] w_mip;
    logic [63:0] w_mcycle;
    logic [63:0] w_minstret;
    logic [31:0] w_rdata;
    logic        w_writable;
    logic [31:0] w_src;
    logic [31:0] w_wdata;
    logic        w_op_legal;
    logic        w_wr;
    logic [31:0] w_pending;
    logic [31:0] w_base;

    assign w_mstatus = MSTATUS_FIXED
                     | (32'(r_mstatus_mie)  << MSTATUS_MIE)
                     | (32'(r_mstatus_mpie) << MSTATUS_MPIE);
    assign w_mip     = 32'(r_mip) << IRQ_BASE;

    // Read mux; counter CSRs only become writable when the counters exist.
    always_comb begin
        w_rdata    = '0;
        w_writable = 1'b0;
        case (addr_i)
            CSR_MSTATUS:   begin w_rdata = w_mstatus;         w_writable = 1'b1;        end
            CSR_MIE:       begin w_rdata = r_mie;             w_writable = 1'b1;        end
            CSR_MTVEC:     begin w_rdata = r_mtvec;           w_writable = 1'b1;        end
            CSR_MSCRATCH:  begin w_rdata = r_mscratch;        w_writable = 1'b1;        end
            CSR_MEPC:      begin w_rdata = r_mepc;            w_writable = 1'b1;        end
            CSR_MCAUSE:    begin w_rdata = r_mcause;          w_writable = 1'b1;        end
            CSR_MIP:       begin w_rdata = w_mip;                                       end
            CSR_MCYCLE:    begin w_rdata = w_mcycle[31:0];    w_writable = COUNTERS_EN; end
            CSR_MCYCLEH:   begin w_rdata = w_mcycle[63:32];   w_writable = COUNTERS_EN; end
            CSR_MINSTRET:  begin w_rdata = w_minstret[31:0];  w_writable = COUNTERS_EN; end
            CSR_MINSTRETH: begin w_rdata = w_minstret[63:32]; w_writable = COUNTERS_EN; end
            default:       begin w_rdata = '0;                w_writable = 1'b0;        end
        endcase
    end

    assign w_src = opcode_i[2] ? imm_data_i : rs1_data_i;

    always_comb begin
        w_wdata    = w_rdata;
        w_op_legal = 1'b1;
        case (opcode_i)
            CSR_RW, CSR_RWI: w_wdata = w_src;
            CSR_RS, CSR_RSI: w_wdata = w_rdata | w_src;
            CSR_RC, CSR_RCI: w_wdata = w_rdata & ~w_src;
            default:         w_op_legal = 1'b0;
        endcase
    end

    assign w_wr      = write_enable_i && w_op_legal && w_writable;
    assign illegal_o = write_enable_i && !(w_op_legal && w_writable);

    // Trap entry outranks mret, which outranks software writes to the same state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= '0;
            r_mtvec        <= MTVEC_RESET;
            r_mscratch     <= '0;
            r_mepc         <= '0;
            r_mcause       <= '0;
            r_mip          <= '0;
        end else begin
            r_mip <= irq_i;
            if (w_wr && addr_i == CSR_MIE)      r_mie      <= w_wdata & C_MIE_MASK;
            if (w_wr && addr_i == CSR_MTVEC)    r_mtvec    <= w_wdata[1] ? (w_wdata & ~32'h3) : w_wdata;
            if (w_wr && addr_i == CSR_MSCRATCH) r_mscratch <= w_wdata;
            if (trap_i) begin
                r_mepc         <= pc_i & ~32'h3;
                r_mcause       <= mcause_i;
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
            end else begin
                if (w_wr && addr_i == CSR_MEPC)   r_mepc   <= w_wdata & ~32'h3;
                if (w_wr && addr_i == CSR_MCAUSE) r_mcause <= w_wdata;
                if (mret_i) begin
                    r_mstatus_mie  <= r_mstatus_mpie;
                    r_mstatus_mpie <= 1'b1;
                end else if (w_wr && addr_i == CSR_MSTATUS) begin
                    r_mstatus_mie  <= w_wdata[MSTATUS_MIE];
                    r_mstatus_mpie <= w_wdata[MSTATUS_MPIE];
                end
            end
        end
    end

    generate
        if (COUNTERS_EN) begin : g_counters
            csr_counter64 u_mcycle (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .inc_i   (1'b1),
                .wr_lo_i (w_wr && addr_i == CSR_MCYCLE),
                .wr_hi_i (w_wr && addr_i == CSR_MCYCLEH),
                .wdata_i (w_wdata),
                .count_o (w_mcycle)
            );
            csr_counter64 u_minstret (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .inc_i   (instret_i),
                .wr_lo_i (w_wr && addr_i == CSR_MINSTRET),
                .wr_hi_i (w_wr && addr_i == CSR_MINSTRETH),
                .wdata_i (w_wdata),
                .count_o (w_minstret)
            );
        end else begin : g_no_counters
            assign w_mcycle   = '0;
            assign w_minstret = '0;
        end
    endgenerate

    assign w_pending = r_mie & w_mip;
    assign irq_req_o = r_mstatus_mie && (|w_pending);

    // Scanning from the top leaves the lowest pending line as the final assignment.
    always_comb begin
        irq_cause_o = '0;
        for (int k = IRQ_NUM - 1; k >= 0; k--) begin
            if (w_pending[IRQ_BASE + k]) irq_cause_o = {1'b1, 31'(IRQ_BASE + k)};
        end
    end

    assign w_base    = {r_mtvec[31:2], 2'b00};
    assign trap_pc_o = (r_mtvec[1:0] == 2'b01 && mcause_i[31]) ? (w_base + (mcause_i << 2)) : w_base;

    assign read_data_o = w_rdata;
    assign mie_o       = r_mie;
    assign mepc_o      = r_mepc;

endmodule
`default_nettype wire

// File: tb/tb_csr_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_unit
// Brief    : Directed and random checks of csr_unit against a behavioural CSR model.
// Revision : 1.0
// ============================================================================
module tb_csr_unit;
    import csr_pkg::*;

    localparam int          IRQ_NUM   = 16;
    localparam logic [31:0] MTVEC_RST = 32'h0000_0201;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic               trap_i, mret_i, write_enable_i, instret_i;
    logic [2:0]         opcode_i;
    logic [11:0]        addr_i;
    logic [31:0]        pc_i, mcause_i, rs1_data_i, imm_data_i;
    logic [IRQ_NUM-1:0] irq_i;
    logic [31:0]        read_data_o, mie_o, mepc_o, trap_pc_o, irq_cause_o;
    logic               illegal_o, irq_req_o;

    csr_unit #(.IRQ_NUM(IRQ_NUM), .MTVEC_RESET(MTVEC_RST), .COUNTERS_EN(1'b1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .trap_i(trap_i), .mret_i(mret_i),
        .opcode_i(opcode_i), .addr_i(addr_i), .write_enable_i(write_enable_i),
        .pc_i(pc_i), .mcause_i(mcause_i), .rs1_data_i(rs1_data_i), .imm_data_i(imm_data_i),
        .irq_i(irq_i), .instret_i(instret_i), .read_data_o(read_data_o), .illegal_o(illegal_o),
        .mie_o(mie_o), .mepc_o(mepc_o), .trap_pc_o(trap_pc_o), .irq_req_o(irq_req_o),
        .irq_cause_o(irq_cause_o)
    );

    always #5 clk_i = ~clk_i;

    int compared   = 0;
    int mismatched = 0;

    // Architectural state of the reference model
    bit          m_ie, m_pie;
    logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mip;
    logic [63:0] m_cyc, m_ins;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        return 32'h0000_1800 | (m_ie ? 32'h8 : 32'h0) | (m_pie ? 32'h80 : 32'h0);
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_status();
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return m_mip;
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB02: return m_ins[31:0];
            12'hB82: return m_ins[63:32];
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_writable(input logic [11:0] a);
        return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                         12'hB00, 12'hB80, 12'hB02, 12'hB82};
    endfunction

    function automatic bit m_illegal();
        return write_enable_i && !(opcode_i inside {3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7}
                                   && m_writable(addr_i));
    endfunction

    function automatic logic [31:0] m_trap_pc();
        logic [31:0] base;
        logic [63:0] t;
        base = m_mtvec & 32'hFFFF_FFFC;
        if (m_mtvec[1:0] != 2'd1 || !mcause_i[31]) return base;
        t = 64'(base) + 64'(mcause_i[30:0]) * 64'd4;
        return t[31:0];
    endfunction

    function automatic logic [31:0] m_cause();
        for (int k = 0; k < IRQ_NUM; k++)
            if (m_mip[16 + k] && m_mie[16 + k]) return 32'h8000_0000 + 32'(16 + k);
        return 32'h0;
    endfunction

    task automatic model_reset();
        m_ie = 0; m_pie = 0;
        m_mie = 0; m_mtvec = MTVEC_RST; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mip = 0;
        m_cyc = 0; m_ins = 0;
    endtask

    // Applies one clock edge worth of architectural effects for the current inputs.
    task automatic model_step();
        logic [31:0] old, src, nv;
        bit          wr;
        old = m_read(addr_i);
        src = opcode_i[2] ? imm_data_i : rs1_data_i;
        case (opcode_i[1:0])
            2'd1:    nv = src;
            2'd2:    nv = old | src;
            2'd3:    nv = old & ~src;
            default: nv = old;
        endcase
        wr = write_enable_i && !m_illegal();
        if (wr && addr_i == 12'hB00)      m_cyc[31:0]  = nv;
        else if (wr && addr_i == 12'hB80) m_cyc[63:32] = nv;
        else                              m_cyc = m_cyc + 1;
        if (wr && addr_i == 12'hB02)      m_ins[31:0]  = nv;
        else if (wr && addr_i == 12'hB82) m_ins[63:32] = nv;
        else if (instret_i)               m_ins = m_ins + 1;
        if (wr && addr_i == 12'h304) m_mie = nv & 32'hFFFF_0000;
        if (wr && addr_i == 12'h305) m_mtvec = (nv[1:0] >= 2'd2) ? {nv[31:2], 2'b00} : nv;
        if (wr && addr_i == 12'h340) m_mscratch = nv;
        if (trap_i) begin
            m_mepc = {pc_i[31:2], 2'b00};
            m_mcause = mcause_i;
            m_pie = m_ie;
            m_ie = 0;
        end else begin
            if (wr && addr_i == 12'h341) m_mepc = {nv[31:2], 2'b00};
            if (wr && addr_i == 12'h342) m_mcause = nv;
            if (mret_i) begin
                m_ie = m_pie;
                m_pie = 1;
            end else if (wr && addr_i == 12'h300) begin
                m_ie = nv[3];
                m_pie = nv[7];
            end
        end
        m_mip = {irq_i, 16'h0000};
    endtask

    task automatic check_outputs();
        check("read_data", read_data_o, m_read(addr_i));
        check("illegal", 32'(illegal_o), 32'(m_illegal()));
        check("mie_o", mie_o, m_mie);
        check("mepc_o", mepc_o, m_mepc);
        check("trap_pc", trap_pc_o, m_trap_pc());
        check("irq_req", 32'(irq_req_o), 32'(m_ie && ((m_mip & m_mie) != 0)));
        check("irq_cause", irq_cause_o, m_cause());
    endtask

    task automatic tick();
        #1;
        check_outputs();
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
    endtask

    task automatic idle();
        trap_i = 0; mret_i = 0; write_enable_i = 0; instret_i = 0;
        opcode_i = 0; addr_i = 0; pc_i = 0; mcause_i = 0; rs1_data_i = 0; imm_data_i = 0;
    endtask

    task automatic csr(input logic [2:0] op, input logic [11:0] a, input logic [31:0] v);
        write_enable_i = 1; opcode_i = op; addr_i = a; rs1_data_i = v; imm_data_i = v;
        tick();
        idle();
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
        addr_i = a;
        #1;
        check(tag, read_data_o, exp);
        tick();
        idle();
    endtask

    localparam logic [11:0] ADDRS [14] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                          12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h7C0,
                                          12'h301, 12'hFFF};

    initial begin
        idle();
        irq_i = '0;
        model_reset();
        repeat (2) @(negedge clk_i);
        addr_i = 12'h300;
        #1;
        check("rst_mstatus", read_data_o, 32'h0000_1800);
        rst_i = 0;
        idle();

        // Reset mid-stream, with a write pending, clears everything
        csr(CSR_RW, 12'h304, 32'hFFFF_FFFF);
        rd(12'h304, 32'hFFFF_0000, "mie_mask");
        rst_i = 1; write_enable_i = 1; opcode_i = CSR_RW; addr_i = 12'h340; rs1_data_i = 32'hDEAD_BEEF;
        #1;
        model_reset();
        check("rst_mie_o", mie_o, 32'h0);
        check("rst_irq_req", 32'(irq_req_o), 32'h0);
        @(posedge clk_i);
        @(negedge clk_i);
        idle();
        addr_i = 12'h300;
        #1;
        check("rst_mstatus2", read_data_o, 32'h0000_1800);
        addr_i = 12'h305;
        #1;
        check("rst_mtvec", read_data_o, MTVEC_RST);
        rst_i = 0;
        rd(12'h340, 32'h0, "rst_mscratch");

        // Set/clear semantics and WARL masks
        csr(CSR_RS, 12'h304, 32'h0001_0001);
        rd(12'h304, 32'h0001_0000, "mie_rs");
        csr(CSR_RC, 12'h304, 32'h0001_0000);
        rd(12'h304, 32'h0, "mie_rc");
        csr(CSR_RW, 12'h305, 32'h0000_1003);
        rd(12'h305, 32'h0000_1000, "mtvec_warl");

        // Trap entry into a vectored handler, then mret
        csr(CSR_RSI, 12'h300, 32'h8);
        csr(CSR_RW, 12'h305, 32'h0000_0101);
        trap_i = 1; pc_i = 32'h2002; mcause_i = 32'h8000_0013;
        #1;
        check("trap_pc_vec", trap_pc_o, 32'h0000_014C);
        tick();
        idle();
        rd(12'h341, 32'h0000_2000, "trap_mepc");
        rd(12'h342, 32'h8000_0013, "trap_mcause");
        rd(12'h300, 32'h0000_1880, "trap_mstatus");
        mret_i = 1;
        tick();
        idle();
        rd(12'h300, 32'h0000_1888, "mret_mstatus");

        // Interrupt priority: the lowest pending line wins
        csr(CSR_RW, 12'h304, 32'h0005_0000);
        irq_i = 16'h0005;
        #1;
        check("irq_sync_delay", 32'(irq_req_o), 32'h0);
        tick();
        #1;
        check("irq_req_rise", 32'(irq_req_o), 32'h1);
        check("irq_cause_low", irq_cause_o, 32'h8000_0010);
        irq_i = 16'h0004;
        tick();
        #1;
        check("irq_cause_2", irq_cause_o, 32'h8000_0012);
        csr(CSR_RC, 12'h300, 32'h8);
        #1;
        check("irq_req_mie0", 32'(irq_req_o), 32'h0);
        irq_i = '0;

        // Counter wrap and write-over-increment precedence
        csr(CSR_RW, 12'hB00, 32'hFFFF_FFFF);
        csr(CSR_RW, 12'hB80, 32'hFFFF_FFFF);
        tick();
        rd(12'hB00, 32'h0, "mcycle_wrap_lo");
        rd(12'hB80, 32'h0, "mcycle_wrap_hi");
        instret_i = 1;
        csr(CSR_RW, 12'hB02, 32'h0000_0055);
        rd(12'hB02, 32'h0000_0055, "minstret_wr");

        // Trap outranks a coincident mepc write; illegal accesses change nothing
        trap_i = 1; pc_i = 32'h0000_3000; mcause_i = 32'h2;
        write_enable_i = 1; opcode_i = CSR_RW; addr_i = 12'h341; rs1_data_i = 32'h40;
        tick();
        idle();
        rd(12'h341, 32'h0000_3000, "trap_vs_write");
        write_enable_i = 1; opcode_i = CSR_RW; addr_i = 12'h7C0; rs1_data_i = 32'h1234;
        #1;
        check("illegal_unmapped", 32'(illegal_o), 32'h1);
        tick();
        write_enable_i = 1; opcode_i = CSR_RW; addr_i = 12'h344; rs1_data_i = 32'hFFFF_FFFF;
        #1;
        check("illegal_mip", 32'(illegal_o), 32'h1);
        tick();
        write_enable_i = 1; opcode_i = 3'd4; addr_i = 12'h340; rs1_data_i = 32'h5555;
        #1;
        check("illegal_opcode", 32'(illegal_o), 32'h1);
        tick();
        idle();
        rd(12'h344, 32'h0, "mip_unchanged");
        rd(12'h340, 32'h0, "mscratch_unchanged");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            addr_i         = ADDRS[$urandom_range(0, 13)];
            opcode_i       = 3'($urandom_range(0, 7));
            write_enable_i = ($urandom_range(0, 2) != 0);
            rs1_data_i     = $urandom;
            imm_data_i     = 32'($urandom_range(0, 31));
            trap_i         = ($urandom_range(0, 7) == 0);
            mret_i         = ($urandom_range(0, 7) == 0);
            pc_i           = $urandom;
            mcause_i       = $urandom;
            irq_i          = 16'($urandom);
            instret_i      = 1'($urandom);
            tick();
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
